// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package if_fetch_pkg;

    // Fetch FSM states; imem_req_o is asserted only in REQ and DRAIN.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2,
        FULL  = 2'd3
    } fetch_state_t;

    // Default instruction driven on inst_o when the IF/ID slot is empty.
    localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

    // Byte distance between consecutive instructions.
    localparam int unsigned INST_INC = 4;

endpackage

// File: rtl/if_skid_buf.sv
// One-entry holding register for a fetched (addr, inst) pair the stalled IF/ID slot cannot take.
// Latency: load visible on skid_vld/skid_addr/skid_dat the cycle after the load edge.
// Backpressure: none of its own; the fetch FSM stops requesting while this entry is occupied.
module if_skid_buf #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
) (
    input  logic              Clk,
    input  logic              Start,
    input  logic              load,
    input  logic              unload,
    input  logic              clear,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [INST_W-1:0] load_dat,
    output logic              skid_vld,
    output logic [ADDR_W-1:0] skid_addr,
    output logic [INST_W-1:0] skid_dat
);

    // Clear (redirect) wins over load, load wins over unload; payload only moves on load.
    always_ff @(posedge Clk or negedge Start) begin
        if (!Start) begin
            skid_vld  <= 1'b0;
            skid_addr <= '0;
            skid_dat  <= '0;
        end else if (clear) begin
            skid_vld  <= 1'b0;
        end else if (load) begin
            skid_vld  <= 1'b1;
            skid_addr <= load_addr;
            skid_dat  <= load_dat;
        end else if (unload) begin
            skid_vld  <= 1'b0;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: owns the PC, runs the imem req/ack handshake, fills the IF/ID slot.
// Latency: ack in cycle N gives valid_o/inst_o in cycle N+1; one instruction per cycle at zero wait.
// Backpressure: stall_i holds the slot; one extra fetch lands in the skid, then requests stop until release.
module if_fetch_unit
    import if_fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [INST_W-1:0] NOP      = INST_W'(NOP_DEFAULT)
) (
    input  logic              Clk,
    input  logic              Start,
    input  logic              stall_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_addr_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [INST_W-1:0] imem_data_i,
    output logic              valid_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [INST_W-1:0] inst_o
);

    localparam logic [ADDR_W-1:0] INC = ADDR_W'(INST_INC);

    fetch_state_t      state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt;
    logic [ADDR_W-1:0] req_addr, req_addr_nxt;
    logic [ADDR_W-1:0] pc_inc;

    logic              out_vld_nxt;
    logic [ADDR_W-1:0] out_addr_nxt;
    logic [INST_W-1:0] out_dat_nxt;

    logic              take_ack;
    logic              skid_load;
    logic              skid_unload;
    logic              skid_clear;
    logic              skid_vld;
    logic [ADDR_W-1:0] skid_addr;
    logic [INST_W-1:0] skid_dat;

    // Wraps modulo 2^ADDR_W; targets are used unaligned as given.
    assign pc_inc = pc + INC;

    // The request address is a register, so it cannot move while a request is open.
    assign imem_req_o  = (state == REQ) || (state == DRAIN);
    assign imem_addr_o = req_addr;

    // State, PC and request-address registers.
    always_ff @(posedge Clk or negedge Start) begin
        if (!Start) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            req_addr <= req_addr_nxt;
        end
    end

    // Next-state, PC update, skid control and IF/ID slot selection; redirect beats stall and ack.
    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        req_addr_nxt = req_addr;
        take_ack     = 1'b0;
        skid_load    = 1'b0;
        skid_unload  = 1'b0;
        skid_clear   = 1'b0;
        out_vld_nxt  = valid_o;
        out_addr_nxt = addr_o;
        out_dat_nxt  = inst_o;

        case (state)
            IDLE: begin
                state_nxt = REQ;
                if (redirect_i) begin
                    pc_nxt       = redirect_addr_i;
                    req_addr_nxt = redirect_addr_i;
                end
            end

            REQ: begin
                if (redirect_i) begin
                    pc_nxt = redirect_addr_i;
                    if (imem_ack_i) begin
                        // Returned word belongs to the wrong path; restart at the target now.
                        req_addr_nxt = redirect_addr_i;
                    end else begin
                        // Memory is committed to req_addr; wait out its ack before retargeting.
                        state_nxt = DRAIN;
                    end
                end else if (imem_ack_i) begin
                    pc_nxt       = pc_inc;
                    req_addr_nxt = pc_inc;
                    if (!valid_o || !stall_i) begin
                        take_ack = 1'b1;
                    end else begin
                        skid_load = 1'b1;
                        state_nxt = FULL;
                    end
                end
            end

            DRAIN: begin
                if (redirect_i) begin
                    pc_nxt = redirect_addr_i;
                end
                if (imem_ack_i) begin
                    req_addr_nxt = redirect_i ? redirect_addr_i : pc;
                    state_nxt    = REQ;
                end
            end

            FULL: begin
                if (redirect_i) begin
                    pc_nxt       = redirect_addr_i;
                    req_addr_nxt = redirect_addr_i;
                    state_nxt    = REQ;
                end else if (!stall_i) begin
                    skid_unload = 1'b1;
                    state_nxt   = REQ;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase

        // IF/ID slot: flush on redirect, else fresh ack data, else skid, else bubble; hold while stalled.
        if (redirect_i) begin
            skid_clear   = 1'b1;
            out_vld_nxt  = 1'b0;
            out_addr_nxt = '0;
            out_dat_nxt  = NOP;
        end else if (take_ack) begin
            out_vld_nxt  = 1'b1;
            out_addr_nxt = pc_inc;
            out_dat_nxt  = imem_data_i;
        end else if (!stall_i) begin
            if (skid_vld) begin
                out_vld_nxt  = 1'b1;
                out_addr_nxt = skid_addr;
                out_dat_nxt  = skid_dat;
            end else begin
                out_vld_nxt  = 1'b0;
                out_addr_nxt = '0;
                out_dat_nxt  = NOP;
            end
        end
    end

    // IF/ID output slot registers.
    always_ff @(posedge Clk or negedge Start) begin
        if (!Start) begin
            valid_o <= 1'b0;
            addr_o  <= '0;
            inst_o  <= NOP;
        end else begin
            valid_o <= out_vld_nxt;
            addr_o  <= out_addr_nxt;
            inst_o  <= out_dat_nxt;
        end
    end

    if_skid_buf #(
        .ADDR_W (ADDR_W),
        .INST_W (INST_W)
    ) u_skid (
        .Clk       (Clk),
        .Start     (Start),
        .load      (skid_load),
        .unload    (skid_unload),
        .clear     (skid_clear),
        .load_addr (pc_inc),
        .load_dat  (imem_data_i),
        .skid_vld  (skid_vld),
        .skid_addr (skid_addr),
        .skid_dat  (skid_dat)
    );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: stream, wait states, stall/skid, redirects, PC wrap, async reset.
// Latency: memory model answers combinationally (zero wait) whenever ack_en is set.
// Backpressure: stall_i and ack_en are driven directly by the step sequence.
module tb_if_fetch_unit;

    localparam logic [31:0] TB_NOP = 32'h0000_0013;

    logic        Clk;
    logic        Start;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_addr_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_data_i;
    logic        valid_o;
    logic [31:0] addr_o;
    logic [31:0] inst_o;

    logic        ack_en;
    int          checks;
    int          errors;

    if_fetch_unit #(
        .ADDR_W   (32),
        .INST_W   (32),
        .RESET_PC (32'h0),
        .NOP      (TB_NOP)
    ) dut (
        .Clk             (Clk),
        .Start           (Start),
        .stall_i         (stall_i),
        .redirect_i      (redirect_i),
        .redirect_addr_i (redirect_addr_i),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_ack_i      (imem_ack_i),
        .imem_data_i     (imem_data_i),
        .valid_o         (valid_o),
        .addr_o          (addr_o),
        .inst_o          (inst_o)
    );

    // Memory returns its own address as the instruction word.
    assign imem_ack_i  = ack_en && imem_req_o;
    assign imem_data_i = imem_addr_o;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] a, input logic [31:0] i);
        check({tag, ".valid_o"}, {31'b0, valid_o}, {31'b0, v});
        check({tag, ".addr_o"}, addr_o, a);
        check({tag, ".inst_o"}, inst_o, i);
    endtask

    task automatic chk_mem(input string tag, input logic r, input logic [31:0] a);
        check({tag, ".imem_req_o"}, {31'b0, imem_req_o}, {31'b0, r});
        check({tag, ".imem_addr_o"}, imem_addr_o, a);
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        Start           = 1'b1;
        stall_i         = 1'b0;
        redirect_i      = 1'b0;
        redirect_addr_i = 32'h0;
        ack_en          = 1'b0;

        // Reset values
        #1 Start = 1'b0;
        #2;
        chk_out("reset", 1'b0, 32'h0, TB_NOP);
        chk_mem("reset", 1'b0, 32'h0);

        // Release; first request one cycle after the first active edge
        @(negedge Clk);
        Start  = 1'b1;
        ack_en = 1'b1;
        @(negedge Clk);
        chk_mem("first_req", 1'b1, 32'h0);
        chk_out("first_req", 1'b0, 32'h0, TB_NOP);

        // Zero-wait stream: one instruction per cycle
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            chk_out("stream", 1'b1, 32'(4 * (i + 1)), 32'(4 * i));
            chk_mem("stream", 1'b1, 32'(4 * (i + 1)));
        end

        // Wait states: request at 0x14 acked in its third cycle
        ack_en = 1'b0;
        @(negedge Clk);
        chk_out("wait1", 1'b0, 32'h0, TB_NOP);
        chk_mem("wait1", 1'b1, 32'h14);
        @(negedge Clk);
        chk_out("wait2", 1'b0, 32'h0, TB_NOP);
        chk_mem("wait2", 1'b1, 32'h14);
        ack_en = 1'b1;
        @(negedge Clk);
        chk_out("wait_done", 1'b1, 32'h18, 32'h14);
        chk_mem("wait_done", 1'b1, 32'h18);

        // Stall for three edges: 0x18 goes to the skid, requests stop
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            chk_out("stall_hold", 1'b1, 32'h18, 32'h14);
            chk_mem("stall_hold", 1'b0, 32'h1C);
        end
        stall_i = 1'b0;
        @(negedge Clk);
        chk_out("stall_rel1", 1'b1, 32'h1C, 32'h18);
        chk_mem("stall_rel1", 1'b1, 32'h1C);
        @(negedge Clk);
        chk_out("stall_rel2", 1'b1, 32'h20, 32'h1C);
        chk_mem("stall_rel2", 1'b1, 32'h20);

        // Redirect coinciding with ack: data dropped, target requested next
        redirect_i      = 1'b1;
        redirect_addr_i = 32'h10;
        @(negedge Clk);
        redirect_i = 1'b0;
        ack_en     = 1'b0;
        chk_out("redir_ack", 1'b0, 32'h0, TB_NOP);
        chk_mem("redir_ack", 1'b1, 32'h10);
        @(negedge Clk);
        chk_mem("pend_hold", 1'b1, 32'h10);

        // Redirect while 0x10 is outstanding: drain it first
        redirect_i      = 1'b1;
        redirect_addr_i = 32'h100;
        @(negedge Clk);
        redirect_i = 1'b0;
        chk_out("drain", 1'b0, 32'h0, TB_NOP);
        chk_mem("drain", 1'b1, 32'h10);
        ack_en = 1'b1;
        @(negedge Clk);
        chk_out("drain_ack", 1'b0, 32'h0, TB_NOP);
        chk_mem("drain_ack", 1'b1, 32'h100);
        @(negedge Clk);
        chk_out("after_drain", 1'b1, 32'h104, 32'h100);
        chk_mem("after_drain", 1'b1, 32'h104);

        // Stall into FULL, then redirect: skid contents are dropped
        stall_i = 1'b1;
        @(negedge Clk);
        chk_out("full", 1'b1, 32'h104, 32'h100);
        chk_mem("full", 1'b0, 32'h108);
        redirect_i      = 1'b1;
        redirect_addr_i = 32'h200;
        @(negedge Clk);
        redirect_i = 1'b0;
        stall_i    = 1'b0;
        chk_out("full_redir", 1'b0, 32'h0, TB_NOP);
        chk_mem("full_redir", 1'b1, 32'h200);
        @(negedge Clk);
        chk_out("full_redir_next", 1'b1, 32'h204, 32'h200);

        // PC wrap at the top of the address space
        redirect_i      = 1'b1;
        redirect_addr_i = 32'hFFFF_FFF8;
        @(negedge Clk);
        redirect_i = 1'b0;
        chk_mem("wrap0", 1'b1, 32'hFFFF_FFF8);
        @(negedge Clk);
        chk_mem("wrap1", 1'b1, 32'hFFFF_FFFC);
        chk_out("wrap1", 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFF8);
        @(negedge Clk);
        chk_mem("wrap2", 1'b1, 32'h0);
        chk_out("wrap2", 1'b1, 32'h0, 32'hFFFF_FFFC);
        @(negedge Clk);
        chk_out("wrap3", 1'b1, 32'h4, 32'h0);

        // Asynchronous reset between edges mid-stream
        #2 Start = 1'b0;
        #1;
        chk_out("async_rst", 1'b0, 32'h0, TB_NOP);
        chk_mem("async_rst", 1'b0, 32'h0);
        @(negedge Clk);
        Start = 1'b1;
        @(negedge Clk);
        chk_mem("restart", 1'b1, 32'h0);
        chk_out("restart", 1'b0, 32'h0, TB_NOP);
        @(negedge Clk);
        chk_out("restart_data", 1'b1, 32'h4, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch front end: owns the PC, drives a request/acknowledge handshake to instruction memory, and writes fetched (PC+4, instruction) pairs into the IF/ID pipeline register. It is the producer for IF/ID's addr/inst inputs. It also absorbs ID-stage stalls with a one-entry skid buffer and handles branch/jump redirects, including redirects that arrive while a memory request is still in flight.

## Interface
- ADDR_W, 32, PC / address width
- INST_W, 32, instruction width
- RESET_PC, 0, first fetch address after reset
- NOP, 0, value driven on inst_o when valid_o=0
- Clk  in  1  clock, rising edge
- Start  in  1  reset, asynchronous, active-low
- stall_i  in  1  IF/ID must hold (hazard unit)
- redirect_i  in  1  taken branch/jump, single-cycle pulse
- redirect_addr_i  in  ADDR_W  redirect target
- imem_req_o  out  1  memory request
- imem_addr_o  out  ADDR_W  request address, registered
- imem_ack_i  in  1  memory response valid; may coincide with req (zero wait)
- imem_data_i  in  INST_W  instruction, valid with ack
- valid_o  out  1  IF/ID slot holds a real instruction
- addr_o  out  ADDR_W  PC+4 of instruction on inst_o
- inst_o  out  INST_W  fetched instruction

## Operation
- Registers: pc, req_addr, output slot (valid_o/addr_o/inst_o), skid (valid/addr/inst), FSM state.
- States: IDLE, REQ, DRAIN, FULL. imem_req_o=1 in REQ and DRAIN only.
- IDLE: entered on reset; next edge → REQ.
- REQ: invariant req_addr==pc. On ack without redirect: pc, req_addr ← pc+4; data goes to the output slot if it is empty or !stall_i, else to the skid → FULL.
- REQ, redirect_i, no ack: pc ← target, req_addr held → DRAIN. Memory is committed to the old address.
- REQ, redirect_i with ack: data discarded; pc, req_addr ← target; stay REQ.
- DRAIN: req held, imem_addr_o stable. Further redirect updates pc only. On ack: data discarded, req_addr ← pc → REQ.
- FULL: no request. When !stall_i: output slot ← skid, skid cleared → REQ.
- Output slot advance when !stall_i: load new ack data, else skid, else bubble (valid_o=0, inst_o=NOP, addr_o=0). Holds all fields while stall_i && valid_o.
- Redirect priority: redirect_i overrides stall_i and ack in every state.
  - valid_o ← 0 and skid cleared.
  - FULL+redirect → REQ with pc=req_addr=target.
- Arithmetic: pc+4 modulo 2^ADDR_W, so 0xFFFFFFFC wraps to 0. No alignment check; target is used as given.
- Handshake rule: once imem_req_o rises, imem_req_o and imem_addr_o stay constant until the ack cycle.

## Timing
- Reset (async, Start=0): valid_o=0, addr_o=0, inst_o=NOP, imem_req_o=0, imem_addr_o=RESET_PC, pc=RESET_PC, skid empty, state IDLE.
- First request: imem_req_o rises one cycle after the first edge with Start=1.
- Latency: ack in cycle N → valid_o/inst_o in cycle N+1.
- Throughput: one instruction per cycle with zero-wait memory.
- Redirect cycle N → valid_o=0 at N+1.
  - No request outstanding: imem_addr_o=target at N+1.
  - Request outstanding: target issued the cycle after the drain ack.
- Reset mid-transaction: the outstanding request is abandoned. Memory must tolerate req dropping.

## Structure
- Package if_fetch_pkg holds: state enum (IDLE/REQ/DRAIN/FULL), NOP default, instruction-increment constant 4.
- Sub-module if_skid_buf: one-entry valid/addr/inst holding register with load/unload/clear. The FSM and PC stay in the top.

## Test plan
- Stream: RESET_PC=0, ack every cycle, data=addr. imem_addr_o 0,4,8,…; from the second fetch cycle onward addr_o 4,8,12,…, inst_o 0,4,8, valid_o=1 continuously.
- Wait states: ack 2 cycles after req. imem_addr_o held 3 cycles; valid_o=0 and inst_o=NOP in the gap; no duplicates.
- Stall: stall_i=1 for 3 cycles under a zero-wait stream. One instruction enters the skid, state FULL, imem_req_o=0. After release: outputs continue in order, no loss or duplicate.
- Redirect with pending request: req at 0x10 unacked, redirect to 0x100. Address stays 0x10 until ack, that data is discarded, next request is 0x100, valid_o=0 throughout.
- Redirect+stall in FULL: skid dropped, valid_o=0 next cycle, next imem_addr_o=target. PC wrap: stream from 0xFFFFFFF8 gives requests 0xFFFFFFF8, 0xFFFFFFFC, 0.
- Async reset between edges mid-stream: outputs go to reset values immediately without a clock. Fetch restarts at RESET_PC.
